// File: rtl/neuron_pkg.sv
// Shared types and helpers for the perceptron datapaths.
//   act_mode_e : activation selector (step / ReLU / identity)
//   state_e    : sequencer states
//   sat_clamp  : clamp a wide signed sum into a WIDTH-bit signed range
package neuron_pkg;

    // Widest sum sat_clamp can handle; callers sign-extend into this width.
    localparam int unsigned SUM_MAX_W = 64;

    typedef enum logic [1:0] {
        ACT_STEP  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_IDENT = 2'd2
    } act_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Clamped value (still SUM_MAX_W wide, caller truncates) plus clamp flag.
    typedef struct packed {
        logic [SUM_MAX_W-1:0] value;
        logic                 sat;
    } clamp_t;

    // Clamp sum to [-2^(width-1), 2^(width-1)-1].
    function automatic clamp_t sat_clamp(input logic signed [SUM_MAX_W-1:0] sum,
                                         input int unsigned                 width);
        logic signed [SUM_MAX_W-1:0] hi;
        logic signed [SUM_MAX_W-1:0] lo;
        clamp_t                      res;
        hi        = $signed((SUM_MAX_W'(1) << (width - 1)) - SUM_MAX_W'(1));
        lo        = ~hi;
        res.value = sum;
        res.sat   = 1'b0;
        if (sum > hi) begin
            res.value = hi;
            res.sat   = 1'b1;
        end else if (sum < lo) begin
            res.value = lo;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/neuron_act.sv
// Combinational ACT stage: rescale accumulator, add bias, clamp, activate.
//   i_acc     : accumulated Q(2*FRAC) products
//   i_bias    : bias in Q.FRAC
//   o_y_c     : activated result
//   o_y_bit_c : 1 when clamped sum >= 0
//   o_sat_c   : pre-activation sum was clamped
module neuron_act
    import neuron_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FRAC     = 4,
    parameter int unsigned ACC_W    = 40,
    parameter int unsigned ACT_MODE = 0
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic signed [WIDTH-1:0] i_bias,
    output logic signed [WIDTH-1:0] o_y_c,
    output logic                    o_y_bit_c,
    output logic                    o_sat_c
);

    localparam act_mode_e MODE = act_mode_e'(ACT_MODE[1:0]);

    if (ACC_W > SUM_MAX_W - 2) begin : g_bad_acc_w
        $error("neuron_act: ACC_W too wide for sat_clamp");
    end
    if (ACT_MODE > 2) begin : g_bad_mode
        $error("neuron_act: ACT_MODE must be 0, 1 or 2");
    end
    if (FRAC + 2 > WIDTH) begin : g_bad_frac
        $error("neuron_act: FRAC leaves no room for 1.0 in WIDTH");
    end

    logic signed [ACC_W-1:0]     w_shift;
    logic signed [SUM_MAX_W-1:0] w_sum;
    clamp_t                      w_clamp;
    logic signed [WIDTH-1:0]     w_s;

    // Product is Q(2*FRAC); floor-shift back to Q.FRAC before adding bias.
    assign w_shift = i_acc >>> FRAC;
    assign w_sum   = SUM_MAX_W'(w_shift) + SUM_MAX_W'(i_bias);
    assign w_clamp = sat_clamp(w_sum, WIDTH);
    assign w_s     = $signed(w_clamp.value[WIDTH-1:0]);

    // Activation on the clamped value.
    always_comb begin
        o_y_c     = w_s;
        o_y_bit_c = ~w_s[WIDTH-1];
        o_sat_c   = w_clamp.sat;
        case (MODE)
            ACT_STEP: begin
                o_y_c = w_s[WIDTH-1] ? '0 : $signed(WIDTH'(1) << FRAC);
            end
            ACT_RELU: begin
                if (w_s[WIDTH-1] || (w_s == '0)) begin
                    o_y_c = '0;
                end
            end
            default: begin
                o_y_c = w_s;
            end
        endcase
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential N-input perceptron: one MAC per cycle, then clamp + activation.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : accept x_vec, w_vec, bias (element i at [i*WIDTH +: WIDTH])
//   out_valid/out_ready : result handshake
//   y, y_bit, sat       : activated result, sign decision, clamp flag
//   busy                : any state other than IDLE
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FRAC     = 4,
    parameter int unsigned ACC_W    = 40,
    parameter int unsigned ACT_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*WIDTH-1:0]   x_vec,
    input  logic [N_IN*WIDTH-1:0]   w_vec,
    input  logic signed [WIDTH-1:0] bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] y,
    output logic                    y_bit,
    output logic                    sat,
    output logic                    busy
);

    localparam int unsigned IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned PROD_W = 2 * WIDTH;

    if (N_IN < 1) begin : g_bad_n_in
        $error("neuron_mac_seq: N_IN must be at least 1");
    end
    if (ACC_W < PROD_W + $clog2(N_IN)) begin : g_bad_acc_w
        $error("neuron_mac_seq: ACC_W too narrow, accumulator could overflow");
    end

    state_e                  r_state;
    state_e                  w_state_d;
    logic                    w_accept;
    logic                    w_mac_en;
    logic                    w_act_en;

    logic signed [WIDTH-1:0] r_x [N_IN];
    logic signed [WIDTH-1:0] r_w [N_IN];
    logic signed [WIDTH-1:0] r_bias;
    logic signed [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0]        r_idx;

    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_busy;
    logic signed [WIDTH-1:0] r_y;
    logic                    r_y_bit;
    logic                    r_sat;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [WIDTH-1:0]  w_y_c;
    logic                     w_y_bit_c;
    logic                     w_sat_c;

    // Full-width signed product of the current element pair.
    assign w_prod = r_x[r_idx] * r_w[r_idx];

    // Next-state and datapath strobes.
    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_mac_en  = 1'b0;
        w_act_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept  = 1'b1;
                    w_state_d = MAC;
                end
            end
            MAC: begin
                w_mac_en = 1'b1;
                if (r_idx == IDX_W'(N_IN - 1)) begin
                    w_state_d = ACT;
                end
            end
            ACT: begin
                w_act_en  = 1'b1;
                w_state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State register; handshake/status flags registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_in_ready  <= (w_state_d == IDLE);
            r_out_valid <= (w_state_d == OUT);
            r_busy      <= (w_state_d != IDLE);
        end
    end

    // Operand capture, accumulation and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_IN); i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
            r_bias  <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_y     <= '0;
            r_y_bit <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < int'(N_IN); i++) begin
                    r_x[i] <= $signed(x_vec[i*WIDTH +: WIDTH]);
                    r_w[i] <= $signed(w_vec[i*WIDTH +: WIDTH]);
                end
                r_bias <= bias;
                r_acc  <= '0;
                r_idx  <= '0;
            end
            if (w_mac_en) begin
                r_acc <= r_acc + ACC_W'(w_prod);
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_act_en) begin
                r_y     <= w_y_c;
                r_y_bit <= w_y_bit_c;
                r_sat   <= w_sat_c;
            end
        end
    end

    neuron_act #(
        .WIDTH    (WIDTH),
        .FRAC     (FRAC),
        .ACC_W    (ACC_W),
        .ACT_MODE (ACT_MODE)
    ) u_act (
        .i_acc     (r_acc),
        .i_bias    (r_bias),
        .o_y_c     (w_y_c),
        .o_y_bit_c (w_y_bit_c),
        .o_sat_c   (w_sat_c)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign y         = r_y;
    assign y_bit     = r_y_bit;
    assign sat       = r_sat;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: four configurations share clk/rst_n.
//   k=0 AND    : N_IN=2, WIDTH=8,  FRAC=4, step
//   k=1 LAT    : N_IN=4, WIDTH=16, FRAC=4, step
//   k=2 SAT    : N_IN=2, WIDTH=16, FRAC=4, identity
//   k=3 RELU   : N_IN=2, WIDTH=16, FRAC=4, ReLU
module tb_neuron_mac_seq;

    logic clk;
    logic rst_n;

    logic [3:0]  iv;
    logic [3:0]  ordy;
    logic [63:0] xv [4];
    logic [63:0] wv [4];
    logic [15:0] bv [4];

    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [3:0]  yb;
    logic [3:0]  st;
    logic [3:0]  bz;
    logic [15:0] yv [4];

    logic        and_ir, and_ov, and_yb, and_st, and_bz;
    logic [7:0]  and_y;
    logic        lat_ir, lat_ov, lat_yb, lat_st, lat_bz;
    logic [15:0] lat_y;
    logic        sat_ir, sat_ov, sat_yb, sat_st, sat_bz;
    logic [15:0] sat_y;
    logic        rel_ir, rel_ov, rel_yb, rel_st, rel_bz;
    logic [15:0] rel_y;

    int n_tests;
    int n_fail;

    assign ir = {rel_ir, sat_ir, lat_ir, and_ir};
    assign ov = {rel_ov, sat_ov, lat_ov, and_ov};
    assign yb = {rel_yb, sat_yb, lat_yb, and_yb};
    assign st = {rel_st, sat_st, lat_st, and_st};
    assign bz = {rel_bz, sat_bz, lat_bz, and_bz};
    assign yv[0] = 16'($signed(and_y));
    assign yv[1] = lat_y;
    assign yv[2] = sat_y;
    assign yv[3] = rel_y;

    neuron_mac_seq #(.N_IN(2), .WIDTH(8), .FRAC(4), .ACC_W(40), .ACT_MODE(0)) u_and (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(and_ir),
        .x_vec(xv[0][15:0]), .w_vec(wv[0][15:0]), .bias(bv[0][7:0]),
        .out_valid(and_ov), .out_ready(ordy[0]), .y(and_y), .y_bit(and_yb),
        .sat(and_st), .busy(and_bz));

    neuron_mac_seq #(.N_IN(4), .WIDTH(16), .FRAC(4), .ACC_W(40), .ACT_MODE(0)) u_lat (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(lat_ir),
        .x_vec(xv[1]), .w_vec(wv[1]), .bias(bv[1]),
        .out_valid(lat_ov), .out_ready(ordy[1]), .y(lat_y), .y_bit(lat_yb),
        .sat(lat_st), .busy(lat_bz));

    neuron_mac_seq #(.N_IN(2), .WIDTH(16), .FRAC(4), .ACC_W(40), .ACT_MODE(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(sat_ir),
        .x_vec(xv[2][31:0]), .w_vec(wv[2][31:0]), .bias(bv[2]),
        .out_valid(sat_ov), .out_ready(ordy[2]), .y(sat_y), .y_bit(sat_yb),
        .sat(sat_st), .busy(sat_bz));

    neuron_mac_seq #(.N_IN(2), .WIDTH(16), .FRAC(4), .ACC_W(40), .ACT_MODE(1)) u_rel (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(rel_ir),
        .x_vec(xv[3][31:0]), .w_vec(wv[3][31:0]), .bias(bv[3]),
        .out_valid(rel_ov), .out_ready(ordy[3]), .y(rel_y), .y_bit(rel_yb),
        .sat(rel_st), .busy(rel_bz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pk2b(input int a, input int b);
        return {48'h0, 8'(b), 8'(a)};
    endfunction

    function automatic logic [63:0] pk2(input int a, input int b);
        return {32'h0, 16'(b), 16'(a)};
    endfunction

    function automatic logic [63:0] pk4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // One full transaction on instance k with out_ready high; returns the result.
    task automatic txn(input int k, input logic [63:0] x, input logic [63:0] w,
                       input logic [15:0] b, output logic [15:0] yo,
                       output logic ybo, output logic sto, output bit to);
        @(negedge clk);
        xv[k]   = x;
        wv[k]   = w;
        bv[k]   = b;
        iv[k]   = 1'b1;
        ordy[k] = 1'b1;
        @(negedge clk);
        iv[k] = 1'b0;
        to  = 1'b1;
        yo  = 'x;
        ybo = 1'bx;
        sto = 1'bx;
        for (int c = 0; c < 30; c++) begin
            if (ov[k]) begin
                yo  = yv[k];
                ybo = yb[k];
                sto = st[k];
                to  = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({ir[k], ov[k], yb[k], st[k], bz[k]} !== 5'b10000 || yv[k] !== 16'h0) begin
                $display("FAIL reset k=%0d: ir/ov/yb/sat/busy=%b y=%h, need 10000 y=0000",
                         k, {ir[k], ov[k], yb[k], st[k], bz[k]}, yv[k]);
                n_fail++;
            end
        end
    endtask

    task automatic test_and();
        logic [15:0] y_o;
        logic        yb_o, st_o;
        bit          to;
        // 1.0*1.0 + 1.0*1.0 - 1.5 = 0.5 -> fires
        txn(0, pk2b(16, 16), pk2b(16, 16), 16'h00E8, y_o, yb_o, st_o, to);
        n_tests++;
        if (to || y_o !== 16'd16 || yb_o !== 1'b1 || st_o !== 1'b0) begin
            $display("FAIL and_11: to=%0b y=%0d y_bit=%b sat=%b, need y=16 y_bit=1 sat=0",
                     to, $signed(y_o), yb_o, st_o);
            n_fail++;
        end
        // 1.0 - 1.5 = -0.5 -> silent
        txn(0, pk2b(16, 0), pk2b(16, 16), 16'h00E8, y_o, yb_o, st_o, to);
        n_tests++;
        if (to || y_o !== 16'd0 || yb_o !== 1'b0 || st_o !== 1'b0) begin
            $display("FAIL and_10: to=%0b y=%0d y_bit=%b sat=%b, need y=0 y_bit=0 sat=0",
                     to, $signed(y_o), yb_o, st_o);
            n_fail++;
        end
    endtask

    task automatic test_latency();
        logic exp_ov;
        // acc = 4*256 = 1024, >>>4 = 64 -> step fires
        @(negedge clk);
        xv[1]   = pk4(16, 16, 16, 16);
        wv[1]   = pk4(16, 16, 16, 16);
        bv[1]   = 16'h0;
        iv[1]   = 1'b1;
        ordy[1] = 1'b1;
        @(posedge clk);
        // e counts edges after the acceptance edge; out_valid rises at edge N_IN+1
        for (int e = 0; e <= 5; e++) begin
            @(negedge clk);
            iv[1]  = 1'b0;
            exp_ov = (e == 5);
            n_tests++;
            if (ov[1] !== exp_ov || ir[1] !== 1'b0 || bz[1] !== 1'b1) begin
                $display("FAIL latency e=%0d: out_valid=%b in_ready=%b busy=%b, need %b 0 1",
                         e, ov[1], ir[1], bz[1], exp_ov);
                n_fail++;
            end
        end
        n_tests++;
        if (yv[1] !== 16'd16 || yb[1] !== 1'b1) begin
            $display("FAIL latency_y: y=%0d y_bit=%b, need 16 1", $signed(yv[1]), yb[1]);
            n_fail++;
        end
        @(negedge clk);
        n_tests++;
        if (ov[1] !== 1'b0 || ir[1] !== 1'b1 || bz[1] !== 1'b0) begin
            $display("FAIL latency_idle: out_valid=%b in_ready=%b busy=%b, need 0 1 0",
                     ov[1], ir[1], bz[1]);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        // 32*16 + 16*16 = 768, >>>4 = 48, +5 = 53
        @(negedge clk);
        xv[2]   = pk2(32, 16);
        wv[2]   = pk2(16, 16);
        bv[2]   = 16'd5;
        iv[2]   = 1'b1;
        ordy[2] = 1'b0;
        @(negedge clk);
        iv[2] = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (ov[2]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (!seen) begin
            $display("FAIL bp_wait: out_valid never rose within 30 cycles, need 1");
            n_fail++;
        end
        for (int c = 0; c < 5; c++) begin
            xv[2] = pk2(c + 100, 7);
            iv[2] = c[0];
            @(negedge clk);
            n_tests++;
            if (ov[2] !== 1'b1 || yv[2] !== 16'd53 || ir[2] !== 1'b0) begin
                $display("FAIL bp_hold c=%0d: out_valid=%b y=%0d in_ready=%b, need 1 53 0",
                         c, ov[2], $signed(yv[2]), ir[2]);
                n_fail++;
            end
        end
        iv[2]   = 1'b0;
        ordy[2] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ov[2] !== 1'b0 || ir[2] !== 1'b1 || bz[2] !== 1'b0) begin
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, need 0 1 0",
                     ov[2], ir[2], bz[2]);
            n_fail++;
        end
        @(negedge clk);
        n_tests++;
        if (ov[2] !== 1'b0 || bz[2] !== 1'b0) begin
            $display("FAIL bp_no_extra: out_valid=%b busy=%b, need 0 0", ov[2], bz[2]);
            n_fail++;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] y_o;
        logic        yb_o, st_o;
        bit          to;
        logic [15:0] exp_y   [5];
        logic        exp_yb  [5];
        logic        exp_st  [5];
        logic [63:0] vx      [5];
        logic [63:0] vw      [5];
        logic [15:0] vb      [5];
        // positive clamp: acc 2147352578 >>>4 = 134209536
        vx[0] = pk2(32767, 32767);  vw[0] = pk2(32767, 32767);   vb[0] = 16'd0;
        exp_y[0] = 16'h7FFF; exp_yb[0] = 1'b1; exp_st[0] = 1'b1;
        // negative clamp
        vx[1] = pk2(32767, 32767);  vw[1] = pk2(-32768, -32768); vb[1] = 16'd0;
        exp_y[1] = 16'h8000; exp_yb[1] = 1'b0; exp_st[1] = 1'b1;
        // exactly max: 32767*16 >>>4 = 32767, no clamp
        vx[2] = pk2(32767, 0);      vw[2] = pk2(16, 0);          vb[2] = 16'd0;
        exp_y[2] = 16'h7FFF; exp_yb[2] = 1'b1; exp_st[2] = 1'b0;
        // one past max via bias
        vx[3] = pk2(32767, 0);      vw[3] = pk2(16, 0);          vb[3] = 16'd1;
        exp_y[3] = 16'h7FFF; exp_yb[3] = 1'b1; exp_st[3] = 1'b1;
        // floor shift: -1 >>> 4 = -1
        vx[4] = pk2(-1, 0);         vw[4] = pk2(1, 0);           vb[4] = 16'd0;
        exp_y[4] = 16'hFFFF; exp_yb[4] = 1'b0; exp_st[4] = 1'b0;
        for (int v = 0; v < 5; v++) begin
            txn(2, vx[v], vw[v], vb[v], y_o, yb_o, st_o, to);
            n_tests++;
            if (to || y_o !== exp_y[v] || yb_o !== exp_yb[v] || st_o !== exp_st[v]) begin
                $display("FAIL sat v=%0d: to=%0b y=%h y_bit=%b sat=%b, need y=%h y_bit=%b sat=%b",
                         v, to, y_o, yb_o, st_o, exp_y[v], exp_yb[v], exp_st[v]);
                n_fail++;
            end
        end
    endtask

    task automatic test_relu();
        logic [15:0] y_o;
        logic        yb_o, st_o;
        bit          to;
        txn(3, pk2(16, 16), pk2(-16, 8), 16'd0, y_o, yb_o, st_o, to);
        n_tests++;
        if (to || y_o !== 16'd0 || yb_o !== 1'b0) begin
            $display("FAIL relu_neg: to=%0b y=%0d y_bit=%b, need 0 0", to, $signed(y_o), yb_o);
            n_fail++;
        end
        txn(3, pk2(16, 16), pk2(16, 8), 16'd0, y_o, yb_o, st_o, to);
        n_tests++;
        if (to || y_o !== 16'd24 || yb_o !== 1'b1) begin
            $display("FAIL relu_pos: to=%0b y=%0d y_bit=%b, need 24 1", to, $signed(y_o), yb_o);
            n_fail++;
        end
        // zero sum: ReLU gives 0 but the step decision still fires
        txn(3, pk2(0, 0), pk2(16, 8), 16'd0, y_o, yb_o, st_o, to);
        n_tests++;
        if (to || y_o !== 16'd0 || yb_o !== 1'b1) begin
            $display("FAIL relu_zero: to=%0b y=%0d y_bit=%b, need 0 1", to, $signed(y_o), yb_o);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] y_o;
        logic        yb_o, st_o;
        bit          to;
        bit          leaked;
        @(negedge clk);
        xv[1]   = pk4(16, 16, 16, 16);
        wv[1]   = pk4(16, 16, 16, 16);
        bv[1]   = 16'd0;
        iv[1]   = 1'b1;
        ordy[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[1] = 1'b0;
        @(negedge clk);
        // idx = 1 now
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ir[1] !== 1'b1 || ov[1] !== 1'b0 || bz[1] !== 1'b0 || yv[1] !== 16'h0 || yb[1] !== 1'b0) begin
            $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b y=%h y_bit=%b, need 1 0 0 0000 0",
                     ir[1], ov[1], bz[1], yv[1], yb[1]);
            n_fail++;
        end
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        leaked = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ov[1] || bz[1]) leaked = 1'b1;
        end
        n_tests++;
        if (leaked) begin
            $display("FAIL reset_no_out: out_valid/busy rose after reset, need quiet");
            n_fail++;
        end
        // 16*-16 + 16*-16 = -512, >>>4 = -32 -> step silent
        txn(1, pk4(16, 16, 16, 16), pk4(-16, -16, 0, 0), 16'd0, y_o, yb_o, st_o, to);
        n_tests++;
        if (to || y_o !== 16'd0 || yb_o !== 1'b0 || st_o !== 1'b0) begin
            $display("FAIL reset_fresh: to=%0b y=%0d y_bit=%b sat=%b, need 0 0 0",
                     to, $signed(y_o), yb_o, st_o);
            n_fail++;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        iv      = '0;
        ordy    = '0;
        for (int k = 0; k < 4; k++) begin
            xv[k] = '0;
            wv[k] = '0;
            bv[k] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_and();
        test_latency();
        test_backpressure();
        test_saturation();
        test_relu();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
